seq_alu_unit: RTL and testbench

Parametrised, clocked successor to the combinational datapath ALU. It adds registered results, a start/done handshake, signed overflow detection and an iterative multiply/divide engine with HI/LO registers. It sits in the execute stage of the multi-cycle datapath and is driven by the main control (`ALU_op`) and the instruction funct field.

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/muldiv_iter.sv | 96 +++++++++
 rtl/seq_alu_unit.sv | 155 +++++++++++++++
 tb/tb_seq_alu_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: funct codes, ALU_op encodings, FSM states, op decode.
// Latency: none (types and a pure function only).
// Backpressure: none.
package alu_pkg;

  // ALU_op encodings from the main control; any value with bit 0 set means subtract.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // MIPS funct field values
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, FIX} state_t;

  // Internal operation after decode. OP_DIVZ is a divide whose divisor was zero at issue.
  typedef enum logic [4:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_DIVZ, OP_BAD
  } op_t;

  function automatic op_t decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
    op_t op;
    op = OP_BAD;
    if (alu_op == ALUOP_ADD) begin
      op = OP_ADD;
    end else if (alu_op[0]) begin
      op = OP_SUB;
    end else begin
      case (funct)
        FN_ADD:   op = OP_ADD;
        FN_ADDU:  op = OP_ADDU;
        FN_SUB:   op = OP_SUB;
        FN_SUBU:  op = OP_SUBU;
        FN_AND:   op = OP_AND;
        FN_OR:    op = OP_OR;
        FN_XOR:   op = OP_XOR;
        FN_NOR:   op = OP_NOR;
        FN_SLT:   op = OP_SLT;
        FN_SLTU:  op = OP_SLTU;
        FN_MFHI:  op = OP_MFHI;
        FN_MFLO:  op = OP_MFLO;
        FN_MULT:  op = OP_MULT;
        FN_MULTU: op = OP_MULTU;
        FN_DIV:   op = OP_DIV;
        FN_DIVU:  op = OP_DIVU;
        default:  op = OP_BAD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift-add) / restoring divide, one bit per cycle on operand magnitudes.
// Latency: WIDTH cycles after start; hi/lo (sign-corrected) are stable from then until next start.
// Backpressure: none; the owner must not pulse start while an iteration is running.
// Ports: clk, rst_n (sync, active-low); start loads a/b with is_div/is_signed;
//        hi/lo present the corrected result; last is high during the final iteration cycle.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic             run;
  logic             div_q;
  logic             neg_lo;   // product sign (mult) or quotient sign (div)
  logic             neg_hi;   // remainder sign: follows the dividend
  logic [WIDTH-1:0] hi_r;     // upper product half / partial remainder
  logic [WIDTH-1:0] lo_r;     // multiplier being shifted out / quotient being shifted in
  logic [WIDTH-1:0] m_r;      // multiplicand / divisor magnitude

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  // The most negative value's magnitude still fits unsigned in WIDTH bits.
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign add_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : '0);
  assign shl     = {hi_r, lo_r[WIDTH-1]};
  assign trial   = shl - {1'b0, m_r};

  assign last = run && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      run    <= 1'b0;
      div_q  <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      m_r    <= '0;
    end else if (start) begin
      // Both engines share the load: lo_r holds multiplier or dividend, m_r the other operand.
      cnt    <= '0;
      run    <= 1'b1;
      div_q  <= is_div;
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= a_neg;
      hi_r   <= '0;
      lo_r   <= a_mag;
      m_r    <= b_mag;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (last) run <= 1'b0;
      if (div_q) begin
        if (!trial[WIDTH]) begin
          hi_r <= trial[WIDTH-1:0];
          lo_r <= {lo_r[WIDTH-2:0], 1'b1};
        end else begin
          hi_r <= shl[WIDTH-1:0];
          lo_r <= {lo_r[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_r <= add_sum[WIDTH:1];
        lo_r <= {add_sum[0], lo_r[WIDTH-1:1]};
      end
    end
  end

  // Sign fixup, captured by the owner in its final cycle.
  assign prod     = {hi_r, lo_r};
  assign prod_fix = neg_lo ? -prod : prod;
  assign hi = div_q ? (neg_hi ? -hi_r : hi_r) : prod_fix[2*WIDTH-1:WIDTH];
  assign lo = div_q ? (neg_lo ? -lo_r : lo_r) : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/seq_alu_unit.sv
// Clocked execute-stage ALU with start/done handshake, overflow/zero flags and HI/LO mul/div.
// Latency: single-cycle ops 1 cycle after accept; mult/div WIDTH+1; divide-by-zero 1.
// Backpressure: Start is accepted only while Busy=0; a Start seen while Busy=1 is dropped.
// Ports: clk, rst_n (sync, active-low); Start, ALU_op, FuncCode, A, B request an op;
//        Output/Zero_Flag/Overflow_Flag/Div_Zero/HI/LO are registered results; Busy, Done pulse.
// WIDTH must be even and at least 8.
module seq_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       ALU_op,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Output,
  output logic             Zero_Flag,
  output logic             Overflow_Flag,
  output logic             Div_Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done
);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;

  op_t  op_dec, op_acc;
  logic accept, is_md, md_is_div, md_signed, md_last;
  logic [WIDTH-1:0] md_hi, md_lo;

  logic [WIDTH-1:0] sum, diff, res;
  logic             ov, dz;

  assign op_dec = decode_op(ALU_op, FuncCode);
  // A zero divisor is resolved at issue and never enters the iterative engine.
  assign op_acc = ((op_dec == OP_DIV || op_dec == OP_DIVU) && B == '0) ? OP_DIVZ : op_dec;
  assign accept    = Start && (state == IDLE);
  assign is_md     = (op_acc == OP_MULT) || (op_acc == OP_MULTU) ||
                     (op_acc == OP_DIV)  || (op_acc == OP_DIVU);
  assign md_is_div = (op_acc == OP_DIV) || (op_acc == OP_DIVU);
  assign md_signed = (op_acc == OP_MULT) || (op_acc == OP_DIV);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && is_md),
    .is_div    (md_is_div),
    .is_signed (md_signed),
    .a         (A),
    .b         (B),
    .hi        (md_hi),
    .lo        (md_lo),
    .last      (md_last)
  );

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  // Single-cycle result from the captured operands, consumed in EXEC.
  always_comb begin
    res = '0;
    ov  = 1'b0;
    dz  = 1'b0;
    case (op_q)
      OP_ADD: begin
        res = sum;
        ov  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_ADDU: res = sum;
      OP_SUB: begin
        res = diff;
        ov  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUBU: res = diff;
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_NOR:  res = ~(a_q | b_q);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OP_MFHI: res = HI;
      OP_MFLO: res = LO;
      OP_DIVZ: begin
        res = '1;
        dz  = 1'b1;
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= OP_BAD;
      a_q           <= '0;
      b_q           <= '0;
      Output        <= '0;
      Zero_Flag     <= 1'b1;
      Overflow_Flag <= 1'b0;
      Div_Zero      <= 1'b0;
      HI            <= '0;
      LO            <= '0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op_acc;
            a_q   <= A;
            b_q   <= B;
            Busy  <= 1'b1;
            state <= is_md ? ITER : EXEC;
          end
        end
        EXEC: begin
          Output        <= res;
          Zero_Flag     <= (res == '0);
          Overflow_Flag <= ov;
          Div_Zero      <= dz;
          if (op_q == OP_DIVZ) begin
            HI <= a_q;
            LO <= '1;
          end
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        ITER: begin
          if (md_last) state <= FIX;
        end
        FIX: begin
          HI            <= md_hi;
          LO            <= md_lo;
          Output        <= md_lo;
          Zero_Flag     <= (md_lo == '0);
          Overflow_Flag <= 1'b0;
          Div_Zero      <= 1'b0;
          Done          <= 1'b1;
          Busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit (WIDTH=32 and WIDTH=8 instances) against an arithmetic model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_alu_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, Start;
  logic [1:0]  ALU_op;
  logic [5:0]  FuncCode;
  logic [31:0] A, B, Output, HI, LO;
  logic        Zero_Flag, Overflow_Flag, Div_Zero, Busy, Done;

  logic        st8;
  logic [1:0]  op8;
  logic [5:0]  fn8;
  logic [7:0]  a8, b8, out8, hi8, lo8;
  logic        z8, ov8, dz8, busy8, done8;

  seq_alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .ALU_op(ALU_op), .FuncCode(FuncCode),
    .A(A), .B(B), .Output(Output), .Zero_Flag(Zero_Flag), .Overflow_Flag(Overflow_Flag),
    .Div_Zero(Div_Zero), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
  );

  seq_alu_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .Start(st8), .ALU_op(op8), .FuncCode(fn8),
    .A(a8), .B(b8), .Output(out8), .Zero_Flag(z8), .Overflow_Flag(ov8),
    .Div_Zero(dz8), .HI(hi8), .LO(lo8), .Busy(busy8), .Done(done8)
  );

  int errors = 0;
  int checks = 0;

  // Architectural model state
  logic [31:0] m_out, m_hi, m_lo;
  logic        m_z, m_ov, m_dz;

  task automatic chk(input string tag, input string fld, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  // Computes the architectural effect of one operation; lat is cycles from accept to Done.
  task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    logic [5:0] f;
    longint s, q;
    lat  = 1;
    m_ov = 1'b0;
    m_dz = 1'b0;
    f = (op == 2'b00) ? 6'h20 : (op[0] ? 6'h22 : fn);
    case (f)
      6'h20: begin
        m_out = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        m_ov = (s != longint'($signed(m_out)));
      end
      6'h21: m_out = a + b;
      6'h22: begin
        m_out = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        m_ov = (s != longint'($signed(m_out)));
      end
      6'h23: m_out = a - b;
      6'h24: m_out = a & b;
      6'h25: m_out = a | b;
      6'h26: m_out = a ^ b;
      6'h27: m_out = ~(a | b);
      6'h2A: m_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: m_out = (a < b) ? 32'd1 : 32'd0;
      6'h10: m_out = m_hi;
      6'h12: m_out = m_lo;
      6'h18: begin
        s = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = s;
        m_out = m_lo;
        lat = 33;
      end
      6'h19: begin
        {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
        m_out = m_lo;
        lat = 33;
      end
      6'h1A, 6'h1B: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFFFFFF;
          m_hi = a;
          m_dz = 1'b1;
        end else if (f == 6'h1A) begin
          q = longint'($signed(a)) / longint'($signed(b));
          s = longint'($signed(a)) % longint'($signed(b));
          m_lo = q[31:0];
          m_hi = s[31:0];
          lat = 33;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
          lat = 33;
        end
        m_out = m_lo;
      end
      default: m_out = 32'd0;
    endcase
    m_z = (m_out == 32'd0);
  endtask

  // Issues one op on the 32-bit unit; poke>0 raises a competing Start that many cycles in.
  task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input int poke, input bit chain, input string tag);
    int lat, c;
    model(op, fn, a, b, lat);
    Start = 1'b1; ALU_op = op; FuncCode = fn; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; A = $urandom; B = $urandom;
    FuncCode = 6'($urandom); ALU_op = 2'($urandom_range(3));
    if (lat > 1) chk(tag, "busy", Busy, 1);
    c = 0;
    while (!Done && c < lat + 8) begin
      if (poke > 0 && c == poke) begin
        Start = 1'b1; ALU_op = 2'b00; A = $urandom; B = $urandom;
      end else begin
        Start = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    Start = 1'b0;
    chk(tag, "latency", c, lat);
    chk(tag, "done", Done, 1);
    chk(tag, "out", Output, m_out);
    chk(tag, "zero", Zero_Flag, m_z);
    chk(tag, "ovf", Overflow_Flag, m_ov);
    chk(tag, "divz", Div_Zero, m_dz);
    chk(tag, "hi", HI, m_hi);
    chk(tag, "lo", LO, m_lo);
    chk(tag, "busy_end", Busy, 0);
    if (!chain) begin
      @(posedge clk); #1;
      chk(tag, "done_pulse", Done, 0);
    end
  endtask

  // Multiply/divide on the 8-bit unit (divisor must be nonzero).
  task automatic run8(input logic [5:0] fn, input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [15:0] p;
    int q, r, c;
    case (fn)
      6'h18:   p = 16'(int'($signed(a)) * int'($signed(b)));
      6'h19:   p = {8'b0, a} * {8'b0, b};
      6'h1A: begin
        q = int'($signed(a)) / int'($signed(b));
        r = int'($signed(a)) % int'($signed(b));
        p = {r[7:0], q[7:0]};
      end
      default: p = {a % b, a / b};
    endcase
    st8 = 1'b1; op8 = 2'b10; fn8 = fn; a8 = a; b8 = b;
    @(posedge clk); #1;
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    c = 0;
    while (!done8 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk(tag, "latency", c, 9);
    chk(tag, "hi", hi8, p[15:8]);
    chk(tag, "lo", lo8, p[7:0]);
    chk(tag, "out", out8, p[7:0]);
  endtask

  logic [5:0]  fns   [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                              6'h2B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h3F};
  logic [31:0] edges [4]  = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
  logic [5:0]  md8   [4]  = '{6'h18, 6'h19, 6'h1A, 6'h1B};

  initial begin
    int dcount;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst_n = 1'b0; Start = 1'b0; ALU_op = 2'b00; FuncCode = 6'h00; A = '0; B = '0;
    st8 = 1'b0; op8 = 2'b00; fn8 = 6'h00; a8 = '0; b8 = '0;
    m_out = '0; m_hi = '0; m_lo = '0; m_z = 1'b1; m_ov = 1'b0; m_dz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", "out", Output, 0);
    chk("reset", "zero", Zero_Flag, 1);
    chk("reset", "ovf", Overflow_Flag, 0);
    chk("reset", "divz", Div_Zero, 0);
    chk("reset", "hilo", {HI, LO}, 0);
    chk("reset", "busy_done", {Busy, Done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Logic/arith on a fixed operand pair
    run_op(2'b10, 6'h20, 32'h10696671, 32'h12345678, 0, 0, "add");
    chk("add", "const", Output, 32'h229DBCE9);
    run_op(2'b10, 6'h22, 32'h10696671, 32'h12345678, 0, 0, "sub");
    chk("sub", "const", Output, 32'hFE350FF9);
    run_op(2'b10, 6'h2A, 32'h10696671, 32'h12345678, 0, 0, "slt");
    run_op(2'b10, 6'h27, 32'h10696671, 32'h12345678, 0, 0, "nor");
    chk("nor", "const", Output, 32'hED828986);
    run_op(2'b00, 6'h3F, 32'h10696671, 32'h12345678, 0, 0, "aluop00");
    run_op(2'b01, 6'h20, 32'h10696671, 32'h12345678, 0, 0, "aluop01");

    // Overflow boundaries
    run_op(2'b10, 6'h20, 32'h7FFFFFFF, 32'h1, 0, 0, "add_ovf");
    run_op(2'b10, 6'h21, 32'h7FFFFFFF, 32'h1, 0, 0, "addu_ovf");
    run_op(2'b11, 6'h00, 32'h80000000, 32'h1, 0, 0, "sub_ovf");
    run_op(2'b10, 6'h22, 32'h1234, 32'h1234, 0, 0, "sub_zero");
    run_op(2'b10, 6'h3F, 32'h5, 32'h6, 0, 0, "unknown");

    // Multiply with an ignored Start mid-flight, then divide cases
    run_op(2'b10, 6'h18, 32'hFFFFFFFD, 32'h7, 10, 0, "mult");
    run_op(2'b10, 6'h19, 32'hFFFFFFFD, 32'h7, 10, 0, "multu");
    run_op(2'b10, 6'h10, 32'h0, 32'h0, 0, 0, "mfhi");
    run_op(2'b10, 6'h1A, 32'hFFFFFFF9, 32'h2, 0, 0, "div");
    run_op(2'b10, 6'h1B, 32'd100, 32'd7, 0, 1, "divu");
    run_op(2'b10, 6'h1B, 32'hCAFE0001, 32'h0, 0, 1, "divu_zero");
    run_op(2'b10, 6'h1A, 32'h80000000, 32'hFFFFFFFF, 0, 0, "div_minneg");

    // Reset in the middle of a multiply
    Start = 1'b1; ALU_op = 2'b10; FuncCode = 6'h18; A = 32'hFFFFFFFD; B = 32'h7;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_out = '0; m_hi = '0; m_lo = '0; m_z = 1'b1; m_ov = 1'b0; m_dz = 1'b0;
    chk("midrst", "out", Output, 0);
    chk("midrst", "zero", Zero_Flag, 1);
    chk("midrst", "flags", {Overflow_Flag, Div_Zero}, 0);
    chk("midrst", "hilo", {HI, LO}, 0);
    chk("midrst", "busy_done", {Busy, Done}, 0);
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done) dcount++;
    end
    chk("midrst", "no_done", dcount, 0);
    run_op(2'b10, 6'h12, 32'h0, 32'h0, 0, 0, "mflo_after_rst");

    // Randomised mix
    for (int i = 0; i < 30; i++) begin
      rop = ($urandom_range(3) != 0) ? 2'b10 : ((i % 2 == 0) ? 2'b00 : 2'b11);
      ra  = ($urandom_range(3) == 0) ? edges[$urandom_range(3)] : $urandom;
      rb  = ($urandom_range(7) == 0) ? 32'h0 :
            (($urandom_range(3) == 0) ? edges[$urandom_range(3)] : $urandom);
      run_op(rop, fns[$urandom_range(16)], ra, rb, 0, 1'($urandom_range(1)), $sformatf("rnd%0d", i));
    end

    // WIDTH=8 instance
    run8(6'h18, 8'hF0, 8'h03, "w8_mult");
    chk("w8_mult", "hi_const", hi8, 8'hFF);
    chk("w8_mult", "lo_const", lo8, 8'hD0);
    for (int i = 0; i < 6; i++) begin
      run8(md8[i % 4], 8'($urandom), 8'($urandom) | 8'h01, $sformatf("w8_rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
